// File: rtl/exu_lsu_agu_split_pkg.sv
// Shared types and helpers for the split-capable load/store address generation unit.
package exu_lsu_agu_split_pkg;

    localparam int unsigned XLEN = 32;
    localparam bit SplitEnDefault = 1'b1;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [2:0] {
        StIdle,
        StCmd1,
        StRsp1,
        StCmd2,
        StRsp2,
        StWbck
    } agu_state_e;

    // Size code 2'b11 is not issued; it decodes as a word.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SizeByte: return 3'd1;
            SizeHalf: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_bmask(input logic [1:0] size);
        case (size)
            SizeByte: return 4'b0001;
            SizeHalf: return 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] size_dmask(input logic [1:0] size);
        case (size)
            SizeByte: return 32'h0000_00FF;
            SizeHalf: return 32'h0000_FFFF;
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/exu_lsu_agu_split_if.sv
// Issue, LSU command/response and write-back channels of the AGU.
// slave is the AGU's view; master is the dispatch/LSU environment's view.
interface exu_lsu_agu_split_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ITAG_WIDTH = 2
);
    import exu_lsu_agu_split_pkg::*;

    logic                  i_valid;
    logic                  i_ready;
    logic [XLEN-1:0]       i_rs1;
    logic [XLEN-1:0]       i_rs2;
    logic [XLEN-1:0]       i_imm;
    logic                  i_load;
    logic                  i_store;
    logic [1:0]            i_size;
    logic                  i_usign;
    logic [ITAG_WIDTH-1:0] i_itag;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_read;
    logic [XLEN-1:0]       cmd_wdata;
    logic [3:0]            cmd_wmask;
    logic [ITAG_WIDTH-1:0] cmd_itag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [XLEN-1:0]       rsp_rdata;
    logic                  rsp_err;

    logic                  o_valid;
    logic                  o_ready;
    logic [XLEN-1:0]       o_wdat;
    logic [ITAG_WIDTH-1:0] o_itag;
    logic                  o_err;
    logic                  o_misalgn;

    modport slave (
        input  i_valid, i_rs1, i_rs2, i_imm, i_load, i_store, i_size, i_usign, i_itag,
        output i_ready,
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_itag,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        output o_valid, o_wdat, o_itag, o_err, o_misalgn,
        input  o_ready
    );

    modport master (
        output i_valid, i_rs1, i_rs2, i_imm, i_load, i_store, i_size, i_usign, i_itag,
        input  i_ready,
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, cmd_itag,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        input  o_valid, o_wdat, o_itag, o_err, o_misalgn,
        output o_ready
    );

endinterface

// File: rtl/exu_lsu_agu_dmerge.sv
// Load-data merge: aligns the two-beat read window to the access offset and extends it.
module exu_lsu_agu_dmerge
    import exu_lsu_agu_split_pkg::*;
(
    input  logic [XLEN-1:0] rdata_hi_i,
    input  logic [XLEN-1:0] rdata_lo_i,
    input  logic [1:0]      off_i,
    input  logic [1:0]      size_i,
    input  logic            usign_i,
    output logic [XLEN-1:0] data_o
);

    logic [2*XLEN-1:0] window;
    logic [XLEN-1:0]   shifted;

    assign window  = {rdata_hi_i, rdata_lo_i};
    assign shifted = window[{off_i, 3'b000} +: XLEN];

    always_comb begin
        data_o = shifted;
        case (size_i)
            SizeByte: data_o = {{24{~usign_i & shifted[7]}}, shifted[7:0]};
            SizeHalf: data_o = {{16{~usign_i & shifted[15]}}, shifted[15:0]};
            default:  data_o = shifted;
        endcase
    end

endmodule

// File: rtl/exu_lsu_agu_split.sv
// Stand-alone load/store AGU: one bus beat per aligned access, two beats for misaligned
// accesses when SPLIT_EN=1, one write-back per instruction.
module exu_lsu_agu_split
    import exu_lsu_agu_split_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned ITAG_WIDTH = 2,
    parameter bit          SPLIT_EN   = SplitEnDefault
) (
    input  logic                clk,
    input  logic                rst_n,
    exu_lsu_agu_split_if.slave  bus_io
);

    agu_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  usign_q, usign_d;
    logic                  load_q, load_d;
    logic                  split_q, split_d;
    logic                  misalgn_q, misalgn_d;
    logic                  err_q, err_d;
    logic [XLEN-1:0]       rs2_q, rs2_d;
    logic [XLEN-1:0]       rdata_lo_q, rdata_lo_d;
    logic [XLEN-1:0]       rdata_hi_q, rdata_hi_d;
    logic [ITAG_WIDTH-1:0] itag_q, itag_d;

    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  issue_mis;
    logic [ADDR_WIDTH-1:0] base;
    logic                  beat2;
    logic [2*XLEN-1:0]     st_data;
    logic [7:0]            st_mask;
    logic [XLEN-1:0]       ld_data;

    // Only the low ADDR_WIDTH bits of rs1+imm reach the bus, so the adder is that wide.
    assign issue_addr = bus_io.i_rs1[ADDR_WIDTH-1:0] + bus_io.i_imm[ADDR_WIDTH-1:0];
    assign issue_mis  = ({1'b0, issue_addr[1:0]} + size_nbytes(bus_io.i_size)) > 3'd4;

    assign base    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign beat2   = (state_q == StCmd2);
    assign st_data = {{XLEN{1'b0}}, rs2_q & size_dmask(size_q)} << {addr_q[1:0], 3'b000};
    assign st_mask = {4'b0000, size_bmask(size_q)} << addr_q[1:0];

    exu_lsu_agu_dmerge u_dmerge (
        .rdata_hi_i (rdata_hi_q),
        .rdata_lo_i (rdata_lo_q),
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .usign_i    (usign_q),
        .data_o     (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (bus_io.i_valid) state_d = (issue_mis && !SPLIT_EN) ? StWbck : StCmd1;
            StCmd1: if (bus_io.cmd_ready) state_d = StRsp1;
            // An error on the first beat abandons the second one.
            StRsp1: if (bus_io.rsp_valid) state_d = (split_q && !bus_io.rsp_err) ? StCmd2 : StWbck;
            StCmd2: if (bus_io.cmd_ready) state_d = StRsp2;
            StRsp2: if (bus_io.rsp_valid) state_d = StWbck;
            StWbck: if (bus_io.o_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        size_d     = size_q;
        usign_d    = usign_q;
        load_d     = load_q;
        split_d    = split_q;
        misalgn_d  = misalgn_q;
        err_d      = err_q;
        rs2_d      = rs2_q;
        rdata_lo_d = rdata_lo_q;
        rdata_hi_d = rdata_hi_q;
        itag_d     = itag_q;
        if (state_q == StIdle && bus_io.i_valid) begin
            addr_d     = issue_addr;
            size_d     = bus_io.i_size;
            usign_d    = bus_io.i_usign;
            load_d     = bus_io.i_load;
            split_d    = issue_mis;
            misalgn_d  = issue_mis && !SPLIT_EN;
            err_d      = 1'b0;
            rs2_d      = bus_io.i_rs2;
            rdata_lo_d = '0;
            rdata_hi_d = '0;
            itag_d     = bus_io.i_itag;
        end
        if (state_q == StRsp1 && bus_io.rsp_valid) begin
            rdata_lo_d = bus_io.rsp_rdata;
            err_d      = bus_io.rsp_err;
        end
        if (state_q == StRsp2 && bus_io.rsp_valid) begin
            rdata_hi_d = bus_io.rsp_rdata;
            err_d      = err_q | bus_io.rsp_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            size_q     <= '0;
            usign_q    <= 1'b0;
            load_q     <= 1'b0;
            split_q    <= 1'b0;
            misalgn_q  <= 1'b0;
            err_q      <= 1'b0;
            rs2_q      <= '0;
            rdata_lo_q <= '0;
            rdata_hi_q <= '0;
            itag_q     <= '0;
        end else begin
            addr_q     <= addr_d;
            size_q     <= size_d;
            usign_q    <= usign_d;
            load_q     <= load_d;
            split_q    <= split_d;
            misalgn_q  <= misalgn_d;
            err_q      <= err_d;
            rs2_q      <= rs2_d;
            rdata_lo_q <= rdata_lo_d;
            rdata_hi_q <= rdata_hi_d;
            itag_q     <= itag_d;
        end
    end

    always_comb begin
        bus_io.i_ready   = (state_q == StIdle);
        bus_io.cmd_valid = (state_q == StCmd1) || beat2;
        bus_io.cmd_addr  = beat2 ? base + ADDR_WIDTH'(4) : base;
        bus_io.cmd_read  = load_q;
        bus_io.cmd_wdata = beat2 ? st_data[2*XLEN-1:XLEN] : st_data[XLEN-1:0];
        bus_io.cmd_wmask = beat2 ? st_mask[7:4] : st_mask[3:0];
        bus_io.cmd_itag  = itag_q;
        bus_io.rsp_ready = (state_q == StRsp1) || (state_q == StRsp2);
        bus_io.o_valid   = (state_q == StWbck);
        bus_io.o_itag    = itag_q;
        bus_io.o_err     = err_q;
        bus_io.o_misalgn = misalgn_q;
        bus_io.o_wdat    = (bus_io.o_valid && load_q && !err_q && !misalgn_q) ? ld_data : '0;
    end

    rsp_only_when_waiting: assert property (@(posedge clk) disable iff (!rst_n)
        bus_io.rsp_valid |-> bus_io.rsp_ready);

    cmd_held_until_ready: assert property (@(posedge clk) disable iff (!rst_n)
        (bus_io.cmd_valid && !bus_io.cmd_ready) |=>
            (bus_io.cmd_valid && $stable(bus_io.cmd_addr) && $stable(bus_io.cmd_wdata)
             && $stable(bus_io.cmd_wmask)));

endmodule

// File: tb/tb_exu_lsu_agu_split.sv
// Scoreboard bench for exu_lsu_agu_split: split-mode DUT plus a SPLIT_EN=0 instance.
module tb_exu_lsu_agu_split;
    import exu_lsu_agu_split_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [1:0]  itag;
    } cmd_t;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    typedef struct {
        logic [31:0] wdat;
        logic [1:0]  itag;
        logic        err;
        logic        misalgn;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t exp_cmd_q[$];
    rsp_t rsp_q[$];
    wb_t  exp_wb_q[$];
    bit   rsp_pend, rsp_hs_seen, ns_cmd_seen;

    exu_lsu_agu_split_if #(.ADDR_WIDTH(16), .ITAG_WIDTH(2)) sif ();
    exu_lsu_agu_split_if #(.ADDR_WIDTH(16), .ITAG_WIDTH(2)) nif ();

    exu_lsu_agu_split #(.ADDR_WIDTH(16), .ITAG_WIDTH(2), .SPLIT_EN(1'b1)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (sif)
    );

    exu_lsu_agu_split #(.ADDR_WIDTH(16), .ITAG_WIDTH(2), .SPLIT_EN(1'b0)) u_dut_ns (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (nif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor for the split-mode DUT; handshakes seen here complete at the next edge.
    always @(negedge clk) begin
        cmd_t c;
        wb_t  w;
        if (sif.cmd_valid && sif.cmd_ready) begin
            n_cmp++;
            if (exp_cmd_q.size() == 0) begin
                n_err++;
                $display("FAIL cmd_unexpected: got addr=%h read=%b, required no command",
                         sif.cmd_addr, sif.cmd_read);
            end else begin
                c = exp_cmd_q.pop_front();
                if ({sif.cmd_addr, sif.cmd_read, sif.cmd_itag} !== {c.addr, c.read, c.itag}) begin
                    n_err++;
                    $display("FAIL cmd_hdr: got addr=%h read=%b itag=%0d, required addr=%h read=%b itag=%0d",
                             sif.cmd_addr, sif.cmd_read, sif.cmd_itag, c.addr, c.read, c.itag);
                end
                if (!c.read) begin
                    n_cmp++;
                    if ({sif.cmd_wdata, sif.cmd_wmask} !== {c.wdata, c.wmask}) begin
                        n_err++;
                        $display("FAIL cmd_wdata: got wdata=%h wmask=%b, required wdata=%h wmask=%b",
                                 sif.cmd_wdata, sif.cmd_wmask, c.wdata, c.wmask);
                    end
                end
            end
            rsp_pend = 1'b1;
        end
        if (sif.rsp_valid && sif.rsp_ready) rsp_hs_seen = 1'b1;
        if (sif.o_valid && sif.o_ready) begin
            n_cmp++;
            if (exp_wb_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_unexpected: got wdat=%h, required no write-back", sif.o_wdat);
            end else begin
                w = exp_wb_q.pop_front();
                if ({sif.o_wdat, sif.o_itag, sif.o_err, sif.o_misalgn} !==
                    {w.wdat, w.itag, w.err, w.misalgn}) begin
                    n_err++;
                    $display("FAIL wb: got wdat=%h itag=%0d err=%b mis=%b, required wdat=%h itag=%0d err=%b mis=%b",
                             sif.o_wdat, sif.o_itag, sif.o_err, sif.o_misalgn,
                             w.wdat, w.itag, w.err, w.misalgn);
                end
            end
        end
        if (nif.cmd_valid) ns_cmd_seen = 1'b1;
    end

    // Bus responder: answers each accepted command one cycle later, in order.
    initial begin
        rsp_t r;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_hs_seen) begin
                sif.rsp_valid = 1'b0;
                rsp_hs_seen   = 1'b0;
            end
            if (rsp_pend && !sif.rsp_valid) begin
                rsp_pend = 1'b0;
                if (rsp_q.size() > 0) r = rsp_q.pop_front();
                else r = '{rdata: 32'h0, err: 1'b0};
                sif.rsp_valid = 1'b1;
                sif.rsp_rdata = r.rdata;
                sif.rsp_err   = r.err;
            end
        end
    end

    // Byte-lane reference model of one instruction; pushes commands, responses and write-back.
    task automatic push_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                           input logic ld, input logic [1:0] sz, input logic us,
                           input logic [1:0] tag, input logic [31:0] rd_lo,
                           input logic [31:0] rd_hi, input logic e1, input logic e2);
        logic [31:0] a;
        logic [63:0] wd, rd;
        logic [7:0]  wm;
        logic [31:0] v;
        logic [15:0] base;
        logic        err;
        int          off, nb;
        bit          mis;
        a    = rs1 + imm;
        off  = int'(a[1:0]);
        nb   = (sz == SizeByte) ? 1 : (sz == SizeHalf) ? 2 : 4;
        mis  = (off + nb) > 4;
        wd   = '0;
        wm   = '0;
        v    = '0;
        rd   = {rd_hi, rd_lo};
        base = a[15:0] & 16'hFFFC;
        for (int i = 0; i < nb; i++) begin
            wd[8*(off+i) +: 8] = rs2[8*i +: 8];
            wm[off+i]          = 1'b1;
            v[8*i +: 8]        = rd[8*(off+i) +: 8];
        end
        if (!us && nb < 4) begin
            for (int k = 8 * nb; k < 32; k++) v[k] = v[8*nb-1];
        end
        exp_cmd_q.push_back('{addr: base, read: ld, wdata: wd[31:0], wmask: wm[3:0], itag: tag});
        rsp_q.push_back('{rdata: rd_lo, err: e1});
        err = e1;
        if (mis && !e1) begin
            exp_cmd_q.push_back('{addr: base + 16'd4, read: ld, wdata: wd[63:32], wmask: wm[7:4],
                                  itag: tag});
            rsp_q.push_back('{rdata: rd_hi, err: e2});
            err = e2;
        end
        exp_wb_q.push_back('{wdat: (ld && !err) ? v : 32'h0, itag: tag, err: err, misalgn: 1'b0});
    endtask

    // Called at posedge+1; returns at posedge+1 right after the issue handshake.
    task automatic issue(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic ld, input logic [1:0] sz, input logic us, input logic [1:0] tag);
        int n;
        sif.i_rs1   = rs1;
        sif.i_rs2   = rs2;
        sif.i_imm   = imm;
        sif.i_load  = ld;
        sif.i_store = !ld;
        sif.i_size  = sz;
        sif.i_usign = us;
        sif.i_itag  = tag;
        sif.i_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!sif.i_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!sif.i_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL issue_timeout: got i_ready=0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        sif.i_valid = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic ld, input logic [1:0] sz, input logic us,
                         input logic [1:0] tag, input logic [31:0] rd_lo,
                         input logic [31:0] rd_hi, input logic e1, input logic e2);
        push_op(rs1, rs2, imm, ld, sz, us, tag, rd_lo, rd_hi, e1, e2);
        issue(rs1, rs2, imm, ld, sz, us, tag);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((exp_wb_q.size() != 0 || exp_cmd_q.size() != 0) && n < 200);
        if (exp_wb_q.size() != 0 || exp_cmd_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d wb / %0d cmd pending, required 0 / 0",
                     exp_wb_q.size(), exp_cmd_q.size());
            exp_wb_q.delete();
            exp_cmd_q.delete();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({sif.i_ready, sif.cmd_valid, sif.rsp_ready, sif.o_valid, sif.o_err, sif.o_misalgn}
            !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b, required 100000",
                     {sif.i_ready, sif.cmd_valid, sif.rsp_ready, sif.o_valid, sif.o_err, sif.o_misalgn});
        end
        n_cmp++;
        if (sif.o_wdat !== 32'h0) begin
            n_err++;
            $display("FAIL reset_wdat: got %h, required 00000000", sif.o_wdat);
        end
        n_cmp++;
        if ({nif.i_ready, nif.cmd_valid, nif.rsp_ready, nif.o_valid, nif.o_err, nif.o_misalgn}
            !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_ctrl_ns: got %b, required 100000",
                     {nif.i_ready, nif.cmd_valid, nif.rsp_ready, nif.o_valid, nif.o_err, nif.o_misalgn});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw_latency();
        int lat;
        do_op(32'h1000, 32'h0, 32'h4, 1'b1, SizeWord, 1'b0, 2'd1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!sif.o_valid && lat < 10);
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL lw_latency: got %0d cycles to o_valid, required 3", lat);
        end
        wait_drain();
    endtask

    task automatic test_byte_loads();
        do_op(32'h1000, 32'h0, 32'h3, 1'b1, SizeByte, 1'b0, 2'd2, 32'h80112233, 32'h0, 1'b0, 1'b0);
        do_op(32'h1000, 32'h0, 32'h3, 1'b1, SizeByte, 1'b1, 2'd3, 32'h80112233, 32'h0, 1'b0, 1'b0);
        wait_drain();
    endtask

    task automatic test_split_load();
        do_op(32'h1000, 32'h0, 32'h2, 1'b1, SizeWord, 1'b0, 2'd0, 32'hAABBCCDD, 32'h11223344,
              1'b0, 1'b0);
        // Second beat wraps from 0xFFFC to 0x0000; upper rs1 bits are outside the bus.
        do_op(32'h1234FFFE, 32'h0, 32'h0, 1'b1, SizeWord, 1'b0, 2'd1, 32'h01020304, 32'hA0B0C0D0,
              1'b0, 1'b0);
        wait_drain();
    endtask

    task automatic test_split_store();
        do_op(32'h2000, 32'h0000BEEF, 32'h3, 1'b0, SizeHalf, 1'b0, 2'd2, 32'h0, 32'h0, 1'b0, 1'b0);
        wait_drain();
    endtask

    task automatic test_nosplit();
        nif.i_rs1   = 32'h2000;
        nif.i_imm   = 32'h1;
        nif.i_rs2   = 32'hCAFEF00D;
        nif.i_load  = 1'b0;
        nif.i_store = 1'b1;
        nif.i_size  = SizeWord;
        nif.i_usign = 1'b0;
        nif.i_itag  = 2'd2;
        nif.i_valid = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (nif.i_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ns_iready: got %b, required 1", nif.i_ready);
        end
        @(posedge clk);
        #1;
        nif.i_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({nif.o_valid, nif.o_misalgn, nif.o_err, nif.o_itag, nif.o_wdat} !==
            {1'b1, 1'b1, 1'b0, 2'd2, 32'h0}) begin
            n_err++;
            $display("FAIL ns_wb: got valid=%b mis=%b err=%b itag=%0d wdat=%h, required 1 1 0 2 00000000",
                     nif.o_valid, nif.o_misalgn, nif.o_err, nif.o_itag, nif.o_wdat);
        end
        @(negedge clk);
        n_cmp++;
        if ({nif.o_valid, nif.i_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL ns_idle: got o_valid=%b i_ready=%b, required 0 1", nif.o_valid, nif.i_ready);
        end
        n_cmp++;
        if (ns_cmd_seen !== 1'b0) begin
            n_err++;
            $display("FAIL ns_no_cmd: got cmd_valid seen=%b, required 0", ns_cmd_seen);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall_err();
        int n;
        sif.cmd_ready = 1'b0;
        sif.o_ready   = 1'b0;
        do_op(32'h3000, 32'h0, 32'h1, 1'b1, SizeWord, 1'b0, 2'd3, 32'h12345678, 32'h9ABCDEF0,
              1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({sif.cmd_valid, sif.cmd_addr, sif.cmd_read, sif.i_ready} !== {1'b1, 16'h3000, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL stall_cmd: got valid=%b addr=%h read=%b i_ready=%b, required 1 3000 1 0",
                         sif.cmd_valid, sif.cmd_addr, sif.cmd_read, sif.i_ready);
            end
        end
        @(posedge clk);
        #1;
        sif.cmd_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sif.o_valid && n < 20);
        repeat (3) begin
            n_cmp++;
            if ({sif.o_valid, sif.o_err, sif.o_wdat, sif.i_ready, sif.cmd_valid} !==
                {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL stall_wb: got valid=%b err=%b wdat=%h i_ready=%b cmd_valid=%b, required 1 1 00000000 0 0",
                         sif.o_valid, sif.o_err, sif.o_wdat, sif.i_ready, sif.cmd_valid);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        sif.o_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [1:0] sz;
        logic       ld;
        for (int i = 0; i < 24; i++) begin
            sz = 2'($urandom_range(0, 2));
            ld = 1'($urandom_range(0, 1));
            do_op($urandom, $urandom, 32'($urandom_range(0, 15)), ld, sz, 1'($urandom_range(0, 1)),
                  2'(i), $urandom, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end
        wait_drain();
    endtask

    task automatic test_mid_reset();
        sif.cmd_ready = 1'b0;
        issue(32'h4000, 32'h0, 32'h0, 1'b1, SizeWord, 1'b0, 2'd1);
        @(negedge clk);
        n_cmp++;
        if (sif.cmd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre: got cmd_valid=%b, required 1", sif.cmd_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sif.cmd_valid, sif.i_ready, sif.rsp_ready, sif.o_valid} !== 4'b0100) begin
            n_err++;
            $display("FAIL midrst: got cmd_valid=%b i_ready=%b rsp_ready=%b o_valid=%b, required 0 1 0 0",
                     sif.cmd_valid, sif.i_ready, sif.rsp_ready, sif.o_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sif.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        do_op(32'h1006, 32'h0, 32'h0, 1'b1, SizeHalf, 1'b0, 2'd2, 32'h80012345, 32'h0, 1'b0, 1'b0);
        wait_drain();
    endtask

    initial begin
        rst_n = 1'b0;
        sif.i_valid = 1'b0; sif.i_rs1 = '0; sif.i_rs2 = '0; sif.i_imm = '0;
        sif.i_load = 1'b0; sif.i_store = 1'b0; sif.i_size = '0; sif.i_usign = 1'b0; sif.i_itag = '0;
        sif.cmd_ready = 1'b1; sif.rsp_valid = 1'b0; sif.rsp_rdata = '0; sif.rsp_err = 1'b0;
        sif.o_ready = 1'b1;
        nif.i_valid = 1'b0; nif.i_rs1 = '0; nif.i_rs2 = '0; nif.i_imm = '0;
        nif.i_load = 1'b0; nif.i_store = 1'b0; nif.i_size = '0; nif.i_usign = 1'b0; nif.i_itag = '0;
        nif.cmd_ready = 1'b1; nif.rsp_valid = 1'b0; nif.rsp_rdata = '0; nif.rsp_err = 1'b0;
        nif.o_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_lw_latency();
        test_byte_loads();
        test_split_load();
        test_split_store();
        test_nosplit();
        test_stall_err();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exu_lsu_agu_split.md
Name: exu_lsu_agu_split

Overview:
Stand-alone load/store address generation unit for the EXU, successor to the ALU-shared AGU.
- Computes rs1+imm with its own adder.
- Issues aligned word commands to the LSU/DTCM bus.
- In split mode, performs misaligned halfword/word accesses as two aligned beats, merges load data and sign/zero-extends it.
- Returns one write-back/commit per instruction.
- Sits between the dispatch/ALU issue port and the LSU-ctrl command/response channels.

Parameters:
- ADDR_WIDTH, 16, width of the bus address carried on cmd_addr.
- ITAG_WIDTH, 2, width of the instruction tag.
- SPLIT_EN, 1, selects misaligned handling: 1 = split into two beats; 0 = no bus access, report o_misalgn.
- Data width is fixed at `XLEN = 32.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  issue valid
- i_ready  out  1  issue ready
- i_rs1  in  32  base register
- i_rs2  in  32  store data
- i_imm  in  32  offset
- i_load  in  1  load op
- i_store  in  1  store op
- i_size  in  2  00=byte, 01=halfword, 10=word
- i_usign  in  1  zero-extend load
- i_itag  in  ITAG_WIDTH  instruction tag
- cmd_valid  out  1  bus command valid
- cmd_ready  in  1  bus command ready
- cmd_addr  out  ADDR_WIDTH  word-aligned address (bits[1:0]=0)
- cmd_read  out  1  1 = read
- cmd_wdata  out  32  write data
- cmd_wmask  out  4  byte enables
- cmd_itag  out  ITAG_WIDTH  tag
- rsp_valid  in  1  response valid
- rsp_ready  out  1  response ready
- rsp_rdata  in  32  read data
- rsp_err  in  1  bus error
- o_valid  out  1  write-back valid
- o_ready  in  1  write-back ready
- o_wdat  out  32  load result (0 for stores)
- o_itag  out  ITAG_WIDTH  tag
- o_err  out  1  bus error seen
- o_misalgn  out  1  misaligned and SPLIT_EN=0

Behaviour:
- Clock/reset: single clock clk. rst_n is asynchronous, active-low. All state flops are gnrl_dfflr/dffr style.
- Reset values: state=IDLE; i_ready=1; cmd_valid=0; rsp_ready=0; o_valid=0; o_err=0; o_misalgn=0; o_wdat=0; capture registers=0.
- Address and misalignment:
  - addr = rs1+imm, mod 2^32.
  - off = addr[1:0].
  - nbytes = 1/2/4 by size.
  - misaligned = off+nbytes > 4.
  - base = {addr[ADDR_WIDTH-1:2],2'b00}.
  - Second beat address = base+4, wrapping at 2^ADDR_WIDTH.
- States: IDLE, CMD1, RSP1, CMD2, RSP2, WBCK.
  - IDLE: i_ready=1. On i_valid, capture addr, size, usign, load, rs2 and itag. If misaligned and SPLIT_EN=0 → WBCK with o_misalgn=1, no command issued. Otherwise → CMD1.
  - CMD1: cmd_valid=1, cmd_addr=base. cmd_valid holds and payload stays stable until cmd_ready. cmd_ready → RSP1.
  - RSP1: rsp_ready=1. On rsp_valid: save rdata into the leftover register and record err.
    - If misaligned and no err → CMD2.
    - If err on the first beat, the second beat is skipped → WBCK with o_err=1.
    - Otherwise → WBCK.
  - CMD2: same as CMD1 with base+4. cmd_ready → RSP2.
  - RSP2: on rsp_valid → WBCK. o_err = err1 | err2.
  - WBCK: o_valid=1. On o_ready → IDLE. i_ready is 0 everywhere except IDLE.
- Single-outstanding rule: at most one bus command outstanding. A response is accepted only in RSP states; rsp_valid in other states is ignored (protocol violation, flagged by an assertion).
- Store data: d64 = zero-extended rs2 (size-masked) << (8*off); m8 = ({1,3,15} by size) << off.
  - Beat 1: wdata=d64[31:0], wmask=m8[3:0].
  - Beat 2: wdata=d64[63:32], wmask=m8[7:4].
  - cmd_read = load for both beats.
- Load merge: r64 = {beat2_rdata (0 if single beat), beat1_rdata} >> (8*off). The low 8/16/32 bits are sign-extended (usign=0) or zero-extended. Stores return o_wdat=0.
- Misaligned/error results: o_wdat=0 when o_misalgn or o_err.
- Timing: o_valid rises the cycle after the last rsp handshake. Minimum aligned latency issue→o_valid is 3 cycles with zero back-pressure.
- Reset mid-operation: reset returns to IDLE. Outstanding commands are dropped; the bus owner is reset in the same domain.

Decomposition:
- In defines.v: state encodings (AGU_ST_*), size codes, and the SPLIT_EN default.
- Sub-module exu_lsu_agu_dmerge (combinational): takes {rdata_hi, rdata_lo}, off, size and usign, and produces the extended load result.
- Store mask/data shifting stays inline.

Test Plan:
- lw, rs1=0x1000, imm=4, rdata=0xDEADBEEF → one cmd at addr 0x1004, wmask ignored, cmd_read=1; o_wdat=0xDEADBEEF, o_err=0.
- lb, addr 0x1003, rdata=0x80112233, usign=0 → one cmd at 0x1000; o_wdat=0xFFFFFF80. With lbu → 0x00000080.
- lw, addr 0x1002 (SPLIT_EN=1), rdata1=0xAABBCCDD, rdata2=0x11223344 → cmds at 0x1000 and 0x1004; o_wdat=0x3344AABB.
- sh, addr 0x2003, rs2=0x0000BEEF → beat1 at 0x2000 with wmask=1000, wdata[31:24]=0xEF; beat2 at 0x2004 with wmask=0001, wdata[7:0]=0xBE; o_valid once.
- SPLIT_EN=0, sw at 0x2001 → no cmd_valid ever; o_valid with o_misalgn=1 the cycle after issue.
- Misaligned lw with rsp_err=1 on beat 1, plus cmd_ready/o_ready held low 3 cycles → cmd payload stable while stalled; no second cmd; o_err=1, o_wdat=0; i_ready low until the o handshake.
